// File: rtl/lpddr_cmd_checker_pkg.sv
// Shared types for the LPDDR command checker: command and init-state enums,
// error bit positions and bank count.
package lpddr_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF,
    CMD_MRS,
    CMD_BST
  } cmd_e;

  typedef enum logic [1:0] {
    ST_WAIT_PALL,
    ST_WAIT_REF,
    ST_WAIT_MRS,
    ST_READY
  } init_st_e;

  localparam int ERR_SEQ   = 0;
  localparam int ERR_TRCD  = 1;
  localparam int ERR_TRP   = 2;
  localparam int ERR_STATE = 3;
  localparam int ERR_TRFC  = 4;
  localparam int NERR      = 5;
  localparam int NBANK     = 4;

endpackage

// File: rtl/lpddr_cmd_checker_if.sv
// Command/address bus plus checker status, grouped for the checker (slave) and
// whoever drives the bus and reads the status (master).
interface lpddr_cmd_checker_if;
  import lpddr_pkg::*;

  logic                cke;
  logic                cs_n;
  logic                ras_n;
  logic                cas_n;
  logic                we_n;
  logic [13:0]         a;
  logic [1:0]          ba;
  logic                clr;
  logic                init_done;
  logic [NBANK-1:0]    bank_open;
  logic [NBANK*13-1:0] open_row;
  logic [NERR-1:0]     err_pulse;
  logic [NERR-1:0]     err_sticky;
  logic [15:0]         cmd_cnt;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, a, ba, clr,
    input  init_done, bank_open, open_row, err_pulse, err_sticky, cmd_cnt
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, a, ba, clr,
    output init_done, bank_open, open_row, err_pulse, err_sticky, cmd_cnt
  );

endinterface

// File: rtl/lpddr_cmd_decode.sv
// Combinational decode of the sampled command pins into a command enum.
module lpddr_cmd_decode
  import lpddr_pkg::*;
(
  input  logic i_cke,
  input  logic i_cs_n,
  input  logic i_ras_n,
  input  logic i_cas_n,
  input  logic i_we_n,
  output cmd_e o_cmd
);

  always_comb begin
    o_cmd = CMD_NOP;
    if (i_cke && !i_cs_n) begin
      case ({i_ras_n, i_cas_n, i_we_n})
        3'b011:  o_cmd = CMD_ACT;
        3'b101:  o_cmd = CMD_RD;
        3'b100:  o_cmd = CMD_WR;
        3'b010:  o_cmd = CMD_PRE;
        3'b001:  o_cmd = CMD_REF;
        3'b000:  o_cmd = CMD_MRS;
        3'b110:  o_cmd = CMD_BST;
        default: o_cmd = CMD_NOP;
      endcase
    end
  end

endmodule

// File: rtl/lpddr_cmd_checker.sv
// Passive LPDDR command-bus monitor: init sequence tracking, per-bank state,
// tRCD/tRP/tRFC/tMRD timing checks and sticky error reporting.
module lpddr_cmd_checker
  import lpddr_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3,
  parameter int TRFC = 10,
  parameter int TMRD = 2,
  parameter int NREF = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  lpddr_cmd_checker_if.slave bus
);

  localparam logic [3:0] TRCD_LD = 4'(TRCD - 1);
  localparam logic [3:0] TRP_LD  = 4'(TRP - 1);
  localparam logic [4:0] TRFC_LD = 5'(TRFC - 1);
  localparam logic [4:0] TMRD_LD = 5'(TMRD - 1);
  localparam logic [3:0] NREF_LAST = 4'(NREF - 1);

  cmd_e            w_cmd;
  init_st_e        r_state, w_state_nxt;
  logic [3:0]      r_ref_cnt, w_ref_cnt_nxt;
  logic            w_seq_err;
  logic            w_ready;
  logic            w_a10;
  logic            w_emrs;
  logic [1:0]      w_ba;
  logic [NERR-1:0] w_err;
  logic            w_unused_a13;

  logic [3:0]      r_trcd [NBANK];
  logic [3:0]      r_trp  [NBANK];
  logic [4:0]      r_tglob;
  logic [NBANK-1:0] r_bank_open;
  logic [12:0]     r_open_row [NBANK];
  logic            r_init_done;
  logic [NERR-1:0] r_err_pulse;
  logic [NERR-1:0] r_err_sticky;
  logic [15:0]     r_cmd_cnt;

  lpddr_cmd_decode u_decode (
    .i_cke   (bus.cke),
    .i_cs_n  (bus.cs_n),
    .i_ras_n (bus.ras_n),
    .i_cas_n (bus.cas_n),
    .i_we_n  (bus.we_n),
    .o_cmd   (w_cmd)
  );

  assign w_ba         = bus.ba;
  assign w_a10        = bus.a[10];
  assign w_unused_a13 = bus.a[13];
  assign w_ready      = (r_state == ST_READY);
  assign w_emrs       = (w_cmd == CMD_MRS) && (w_ba == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_WAIT_PALL;
      r_ref_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ref_cnt <= w_ref_cnt_nxt;
    end
  end

  // Illegal init commands flag ERR_SEQ and never advance the sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_ref_cnt_nxt = r_ref_cnt;
    w_seq_err     = 1'b0;
    case (r_state)
      ST_WAIT_PALL: begin
        if (w_cmd == CMD_PRE && w_a10) w_state_nxt = ST_WAIT_REF;
        else if (w_cmd != CMD_NOP)     w_seq_err   = 1'b1;
      end
      ST_WAIT_REF: begin
        if (w_cmd == CMD_REF) begin
          if (r_ref_cnt == NREF_LAST) begin
            w_state_nxt   = ST_WAIT_MRS;
            w_ref_cnt_nxt = '0;
          end else begin
            w_ref_cnt_nxt = r_ref_cnt + 4'd1;
          end
        end else if (!w_emrs && w_cmd != CMD_NOP) begin
          w_seq_err = 1'b1;
        end
      end
      ST_WAIT_MRS: begin
        if (w_cmd == CMD_MRS && w_ba == 2'b00) w_state_nxt = ST_READY;
        else if (!w_emrs && w_cmd != CMD_NOP)  w_seq_err   = 1'b1;
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_WAIT_PALL;
    endcase
  end

  always_comb begin
    w_err           = '0;
    w_err[ERR_SEQ]  = w_seq_err;
    w_err[ERR_TRFC] = (w_cmd != CMD_NOP) && (r_tglob != 5'd0);
    if (w_ready) begin
      case (w_cmd)
        CMD_ACT: begin
          w_err[ERR_TRP]   = (r_trp[w_ba] != 4'd0);
          w_err[ERR_STATE] = r_bank_open[w_ba];
        end
        CMD_RD, CMD_WR: begin
          w_err[ERR_TRCD]  = (r_trcd[w_ba] != 4'd0);
          w_err[ERR_STATE] = !r_bank_open[w_ba];
        end
        CMD_REF, CMD_MRS: w_err[ERR_STATE] = |r_bank_open;
        default: ;
      endcase
    end
  end

  // Per-bank timers and state only move once the device is initialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANK; b++) begin
        r_trcd[b]     <= '0;
        r_trp[b]      <= '0;
        r_open_row[b] <= '0;
      end
      r_bank_open <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (w_ready && w_cmd == CMD_ACT && w_ba == 2'(b))
          r_trcd[b] <= TRCD_LD;
        else if (r_trcd[b] != 4'd0)
          r_trcd[b] <= r_trcd[b] - 4'd1;

        if (w_ready && w_cmd == CMD_PRE && (w_a10 || w_ba == 2'(b)))
          r_trp[b] <= TRP_LD;
        else if (r_trp[b] != 4'd0)
          r_trp[b] <= r_trp[b] - 4'd1;

        if (w_ready && w_cmd == CMD_ACT && w_ba == 2'(b) && !r_bank_open[b]) begin
          r_bank_open[b] <= 1'b1;
          r_open_row[b]  <= bus.a[12:0];
        end else if (w_ready && w_cmd == CMD_PRE && (w_a10 || w_ba == 2'(b))) begin
          r_bank_open[b] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tglob      <= '0;
      r_init_done  <= 1'b0;
      r_err_pulse  <= '0;
      r_err_sticky <= '0;
      r_cmd_cnt    <= '0;
    end else begin
      if (w_cmd == CMD_REF)      r_tglob <= TRFC_LD;
      else if (w_cmd == CMD_MRS) r_tglob <= TMRD_LD;
      else if (r_tglob != 5'd0)  r_tglob <= r_tglob - 5'd1;

      r_init_done <= (w_state_nxt == ST_READY);
      r_err_pulse <= w_err;
      // A fresh error in the clear cycle survives the clear.
      r_err_sticky <= bus.clr ? w_err : (r_err_sticky | w_err);

      if (w_cmd != CMD_NOP && r_cmd_cnt != 16'hFFFF)
        r_cmd_cnt <= r_cmd_cnt + 16'd1;
    end
  end

  assign bus.init_done  = r_init_done;
  assign bus.bank_open  = r_bank_open;
  assign bus.open_row   = {r_open_row[3], r_open_row[2], r_open_row[1], r_open_row[0]};
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_sticky = r_err_sticky;
  assign bus.cmd_cnt    = r_cmd_cnt;

endmodule
